add_mat_seq: RTL

//  Row-serial matrix adder: reconstructs mat_out = mat_d + mat_b, the inverse of the

---
 rtl/add_mat_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/add_mat_seq.sv
// Row-serial matrix adder: mat_out = sat(mat_d + mat_b), one row per clock.
// Operands are snapshotted on an accepted start; the result is clamped to N_BITS
// and sat_flag records any clamp within the current operation.
module add_mat_seq #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int N_BITS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [N_BITS:0]   mat_d   [SIZE_A][SIZE_B],
    input  logic signed [N_BITS-1:0] mat_b   [SIZE_A][SIZE_B],
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag,
    output logic signed [N_BITS-1:0] mat_out [SIZE_A][SIZE_B]
);

    localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int SW = N_BITS + 2;

    // Clamp bounds in the extended sum width and in the output width.
    localparam logic signed [SW-1:0]     S_MAX = {3'b000, {(N_BITS-1){1'b1}}};
    localparam logic signed [SW-1:0]     S_MIN = {3'b111, {(N_BITS-1){1'b0}}};
    localparam logic signed [N_BITS-1:0] O_MAX = {1'b0, {(N_BITS-1){1'b1}}};
    localparam logic signed [N_BITS-1:0] O_MIN = {1'b1, {(N_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [RW-1:0]             row_q, row_d;
    logic                      sat_q, sat_d;
    logic                      accept;
    logic                      write_row;

    logic signed [N_BITS:0]    d_q   [SIZE_A][SIZE_B];
    logic signed [N_BITS-1:0]  b_q   [SIZE_A][SIZE_B];
    logic signed [N_BITS-1:0]  out_q [SIZE_A][SIZE_B];

    logic signed [SW-1:0]      d_ext   [SIZE_B];
    logic signed [SW-1:0]      b_ext   [SIZE_B];
    logic signed [SW-1:0]      sum     [SIZE_B];
    logic signed [N_BITS-1:0]  row_res [SIZE_B];
    logic                      row_sat;

    // Row datapath: exact sign-extended add of the current row, then clamp.
    always_comb begin
        row_sat = 1'b0;
        for (int unsigned j = 0; j < SIZE_B; j++) begin
            d_ext[j] = {d_q[row_q][j][N_BITS], d_q[row_q][j]};
            b_ext[j] = {{2{b_q[row_q][j][N_BITS-1]}}, b_q[row_q][j]};
            sum[j]   = d_ext[j] + b_ext[j];
            if (sum[j] > S_MAX) begin
                row_res[j] = O_MAX;
                row_sat    = 1'b1;
            end else if (sum[j] < S_MIN) begin
                row_res[j] = O_MIN;
                row_sat    = 1'b1;
            end else begin
                row_res[j] = sum[j][N_BITS-1:0];
            end
        end
    end

    // Next-state logic: IDLE accepts start, RUN walks the rows, DONE pulses once.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        sat_d     = sat_q;
        accept    = 1'b0;
        write_row = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                    row_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            S_RUN: begin
                write_row = 1'b1;
                sat_d     = sat_q | row_sat;
                if (row_q == RW'(SIZE_A - 1)) begin
                    state_d = S_DONE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            sat_q   <= sat_d;
        end
    end

    // Operand snapshot taken only when a start is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            d_q <= mat_d;
            b_q <= mat_b;
        end
    end

    // Result matrix: one row written per RUN cycle, other rows hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SIZE_A; i++) begin
                for (int unsigned j = 0; j < SIZE_B; j++) begin
                    out_q[i][j] <= '0;
                end
            end
        end else if (write_row) begin
            for (int unsigned j = 0; j < SIZE_B; j++) begin
                out_q[row_q][j] <= row_res[j];
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign sat_flag = sat_q;
    assign mat_out  = out_q;

endmodule
